// File: rtl/digital_scan.sv
// rtl/digital_scan.sv - six-digit multiplexed 7-segment clock display scanner
// Snapshot-per-frame digit scan with anti-ghost blanking and a blinking colon dot.
module digital_scan #(
    parameter int SCAN_DIV     = 50000,
    parameter int BLANK_CYC    = 500,
    parameter int BLINK_FRAMES = 167,
    parameter int LZB          = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] sec_1,
    input  logic [3:0] sec_2,
    input  logic [3:0] min_1,
    input  logic [3:0] min_2,
    input  logic [3:0] hour_1,
    input  logic [3:0] hour_2,
    output logic [5:0] sel,
    output logic [7:0] seg
);

    localparam int DW = $clog2(SCAN_DIV);
    localparam int FW = $clog2(BLINK_FRAMES + 1);
    localparam logic [DW-1:0] DIV_LAST   = DW'(SCAN_DIV - 1);
    localparam logic [DW-1:0] BLANK_END  = DW'(BLANK_CYC);
    localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);

    logic [DW-1:0]   div_cnt;
    logic [2:0]      idx;
    logic [5:0][3:0] snap;
    logic [FW-1:0]   frame_cnt;
    logic            blink;

    logic [3:0] digit;
    logic [7:0] code;
    logic [5:0] sel_nxt;
    logic [7:0] seg_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt   <= '0;
            idx       <= 3'd0;
            snap      <= '0;
            frame_cnt <= '0;
            blink     <= 1'b0;
            sel       <= 6'h3F;
            seg       <= 8'hFF;
        end else begin
            sel <= sel_nxt;
            seg <= seg_nxt;
            if (div_cnt == DIV_LAST) begin
                div_cnt <= '0;
                if (idx == 3'd5) begin
                    // Frame boundary: latch the whole time at once so no frame is torn.
                    idx  <= 3'd0;
                    snap <= {hour_2, hour_1, min_2, min_1, sec_2, sec_1};
                    if (frame_cnt == FRAME_LAST) begin
                        frame_cnt <= '0;
                        blink     <= ~blink;
                    end else begin
                        frame_cnt <= frame_cnt + FW'(1);
                    end
                end else begin
                    idx <= idx + 3'd1;
                end
            end else begin
                div_cnt <= div_cnt + DW'(1);
            end
        end
    end

    always_comb begin
        sel_nxt = 6'h3F;
        seg_nxt = 8'hFF;
        digit   = snap[idx];
        case (digit)
            4'd0:    code = 8'hC0;
            4'd1:    code = 8'hF9;
            4'd2:    code = 8'hA4;
            4'd3:    code = 8'hB0;
            4'd4:    code = 8'h99;
            4'd5:    code = 8'h92;
            4'd6:    code = 8'h82;
            4'd7:    code = 8'hF8;
            4'd8:    code = 8'h80;
            4'd9:    code = 8'h90;
            default: code = 8'hBF;
        endcase
        if (LZB != 0 && idx == 3'd5 && digit == 4'd0) begin
            code = 8'hFF;
        end
        if (blink && (idx == 3'd2 || idx == 3'd4)) begin
            code[7] = 1'b0;
        end
        if (div_cnt >= BLANK_END) begin
            sel_nxt = ~(6'b000001 << idx);
            seg_nxt = code;
        end
    end

endmodule

// File: tb/tb_digital_scan.sv
// tb/tb_digital_scan.sv - randomized self-checking bench for digital_scan
module tb_digital_scan;

    localparam int SD = 4;
    localparam int BC = 1;
    localparam int BF = 2;
    localparam int FC = SD * 6;
    localparam logic [7:0] ENC [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                        8'h80, 8'h90, 8'hBF, 8'hBF, 8'hBF, 8'hBF, 8'hBF, 8'hBF};

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] sec_1 = 4'd0, sec_2 = 4'd0, min_1 = 4'd0, min_2 = 4'd0, hour_1 = 4'd0, hour_2 = 4'd0;
    logic [5:0] sel, sel0;
    logic [7:0] seg, seg0;

    int vectors = 0;
    int miscompares = 0;
    int n = 0;
    logic [23:0] fsnap [0:1023];

    digital_scan #(.SCAN_DIV(SD), .BLANK_CYC(BC), .BLINK_FRAMES(BF), .LZB(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .sec_1(sec_1), .sec_2(sec_2), .min_1(min_1), .min_2(min_2), .hour_1(hour_1), .hour_2(hour_2),
        .sel(sel), .seg(seg)
    );

    digital_scan #(.SCAN_DIV(SD), .BLANK_CYC(BC), .BLINK_FRAMES(BF), .LZB(0)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .sec_1(sec_1), .sec_2(sec_2), .min_1(min_1), .min_2(min_2), .hour_1(hour_1), .hour_2(hour_2),
        .sel(sel0), .seg(seg0)
    );

    always #5 clk = ~clk;

    // n = rising edges since reset release; a frame's time is captured on the edge that ends the previous frame.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n = 0;
            fsnap[0] = 24'h0;
        end else begin
            n = n + 1;
            if (n % FC == 0 && n / FC < 1024)
                fsnap[n / FC] = {hour_2, hour_1, min_2, min_1, sec_2, sec_1};
        end
    end

    function automatic void model(input int e, input int lzb, output logic [5:0] xs, output logic [7:0] xg);
        int s, div, pos, f;
        logic [3:0] d;
        xs = 6'h3F;
        xg = 8'hFF;
        if (e == 0) return;
        s   = e - 1;
        div = s % SD;
        pos = (s / SD) % 6;
        f   = s / FC;
        if (div < BC) return;
        xs = 6'h3F & ~(6'(1) << pos);
        d  = fsnap[f][4*pos +: 4];
        xg = ENC[d];
        if (lzb != 0 && pos == 5 && d == 4'd0) xg = 8'hFF;
        if (((f / BF) % 2) == 1 && (pos == 2 || pos == 4)) xg[7] = 1'b0;
    endfunction

    task automatic check_cycles(input int cycles);
        logic [5:0] xs;
        logic [7:0] xg;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            model(n, 1, xs, xg);
            vectors++;
            if (sel !== xs) begin
                miscompares++;
                $display("FAIL sel lzb1 edge=%0d got=%b exp=%b", n, sel, xs);
            end
            vectors++;
            if (seg !== xg) begin
                miscompares++;
                $display("FAIL seg lzb1 edge=%0d got=%h exp=%h", n, seg, xg);
            end
            model(n, 0, xs, xg);
            vectors++;
            if (sel0 !== xs) begin
                miscompares++;
                $display("FAIL sel lzb0 edge=%0d got=%b exp=%b", n, sel0, xs);
            end
            vectors++;
            if (seg0 !== xg) begin
                miscompares++;
                $display("FAIL seg lzb0 edge=%0d got=%h exp=%h", n, seg0, xg);
            end
        end
    endtask

    task automatic set_time(input logic [23:0] t);
        {hour_2, hour_1, min_2, min_1, sec_2, sec_1} = t;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        set_time(24'h123456);
        repeat (3) @(negedge clk);
        vectors++;
        if (sel !== 6'h3F || seg !== 8'hFF) begin
            miscompares++;
            $display("FAIL reset_state got sel=%b seg=%h exp sel=111111 seg=ff", sel, seg);
        end
        vectors++;
        if (sel0 !== 6'h3F || seg0 !== 8'hFF) begin
            miscompares++;
            $display("FAIL reset_state_lzb0 got sel=%b seg=%h exp sel=111111 seg=ff", sel0, seg0);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_first_frames;
        check_cycles(2 * FC);
    endtask

    task automatic test_snapshot_tear;
        int guard = 0;
        while ((((n - 1) / SD) % 6) != 2 && guard < 2 * FC) begin
            check_cycles(1);
            guard++;
        end
        vectors++;
        if (guard >= 2 * FC) begin
            miscompares++;
            $display("FAIL tear_sync got guard=%0d exp <%0d", guard, 2 * FC);
        end
        sec_1 = 4'd7;
        check_cycles(2 * FC);
    endtask

    task automatic test_blink;
        check_cycles(6 * FC);
    endtask

    task automatic test_dash;
        hour_2 = 4'hB;
        sec_1  = 4'hF;
        check_cycles(2 * FC);
        hour_2 = 4'h0;
        check_cycles(2 * FC);
    endtask

    task automatic test_random;
        for (int k = 0; k < 40; k++) begin
            set_time(24'($urandom));
            check_cycles($urandom_range(1, 30));
        end
    endtask

    task automatic test_async_reset;
        set_time(24'h123456);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        vectors++;
        if (sel !== 6'h3F || seg !== 8'hFF) begin
            miscompares++;
            $display("FAIL async_reset got sel=%b seg=%h exp sel=111111 seg=ff", sel, seg);
        end
        vectors++;
        if (sel0 !== 6'h3F || seg0 !== 8'hFF) begin
            miscompares++;
            $display("FAIL async_reset_lzb0 got sel=%b seg=%h exp sel=111111 seg=ff", sel0, seg0);
        end
        #2 rst_n = 1'b1;
        check_cycles(2 * FC);
    endtask

    initial begin
        test_reset;
        test_first_frames;
        test_snapshot_tear;
        test_blink;
        test_dash;
        test_random;
        test_async_reset;
        test_random;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
